// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath:
// sequencer states, opcode/funct values and the datapath mux/ALU selects.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE,
    S_R_EXEC, S_R_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WAIT, S_MEM_WB, S_MEM_WRITE,
    S_BRANCH, S_JUMP, S_ADDI_EXEC, S_ADDI_WB,
    S_HALT, S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;

  localparam logic [3:0] SRCB_B       = 4'd0;
  localparam logic [3:0] SRCB_FOUR    = 4'd1;
  localparam logic [3:0] SRCB_IMM     = 4'd2;
  localparam logic [3:0] SRCB_IMM_SH2 = 4'd3;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_INC  = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation select from the sequencer state and the
// instruction's opcode/funct fields.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_sel
);

  logic [2:0] w_funct_op;

  always_comb begin
    w_funct_op = ALU_ADD;
    if (i_op == OP_RTYPE) begin
      case (i_funct)
        FN_SUB:  w_funct_op = ALU_SUB;
        FN_AND:  w_funct_op = ALU_AND;
        FN_XOR:  w_funct_op = ALU_XOR;
        default: w_funct_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    o_alu_sel = ALU_LOAD;
    case (i_state)
      S_FETCH_WAIT, S_DECODE,
      S_MEM_ADDR, S_ADDI_EXEC: o_alu_sel = ALU_ADD;
      S_BRANCH:                o_alu_sel = ALU_SUB;
      S_R_EXEC:                o_alu_sel = w_funct_op;
      default:                 o_alu_sel = ALU_LOAD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS sequencer: one state register, Moore-decoded datapath
// controls (branch pc_load also looks at ALU_zero).
module control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Operation,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  output logic       pc_reset,
  output logic       instReg_reset,
  output logic       a_reset,
  output logic       b_reset,
  output logic       ALUout_reset,
  output logic       pc_load,
  output logic       instReg_load,
  output logic       a_load,
  output logic       b_load,
  output logic       ALUout_load,
  output logic       mdr_load,
  output logic       mem_write,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [3:0] ALUSrcB,
  output logic [2:0] ALU_select,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       halted,
  output logic       illegal_op
);

  state_t r_state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_RESET;
    else begin
      case (r_state)
        S_RESET:      r_state <= S_FETCH;
        S_FETCH:      r_state <= S_FETCH_WAIT;
        S_FETCH_WAIT: r_state <= S_DECODE;
        S_DECODE: begin
          case (Operation)
            OP_RTYPE: begin
              if (Funct == FN_BREAK)  r_state <= S_HALT;
              else if (funct_ok(Funct)) r_state <= S_R_EXEC;
              else                    r_state <= S_ILLEGAL;
            end
            OP_LW, OP_SW:   r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_J:           r_state <= S_JUMP;
            OP_ADDI:        r_state <= S_ADDI_EXEC;
            default:        r_state <= S_ILLEGAL;
          endcase
        end
        S_R_EXEC:    r_state <= S_R_WB;
        S_MEM_ADDR:  r_state <= (Operation == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  r_state <= S_MEM_WAIT;
        S_MEM_WAIT:  r_state <= S_MEM_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_HALT:      r_state <= S_HALT;
        S_ILLEGAL:   r_state <= S_ILLEGAL;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  alu_op_decode u_alu_op_decode (
    .i_state   (r_state),
    .i_op      (Operation),
    .i_funct   (Funct),
    .o_alu_sel (ALU_select)
  );

  // Outputs follow the state register directly so an async Reset kills
  // mem_write/RegWrite without waiting for a clock edge.
  always_comb begin
    {pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset} = '0;
    {pc_load, instReg_load, a_load, b_load, ALUout_load, mdr_load} = '0;
    mem_write = 1'b0;  IorD = 1'b0;  ALUSrcA = 1'b0;
    ALUSrcB   = SRCB_B;
    PCSource  = PC_ALU;
    RegWrite  = 1'b0;  RegDst = 1'b0;  MemtoReg = 1'b0;
    halted    = 1'b0;  illegal_op = 1'b0;
    case (r_state)
      S_RESET: {pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset} = '1;
      S_FETCH_WAIT: begin
        instReg_load = 1'b1;  pc_load = 1'b1;
        ALUSrcB = SRCB_FOUR;  PCSource = PC_ALU;
      end
      S_DECODE: begin
        a_load = 1'b1;  b_load = 1'b1;  ALUout_load = 1'b1;
        ALUSrcB = SRCB_IMM_SH2;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;  ALUSrcB = SRCB_B;  ALUout_load = 1'b1;
      end
      S_R_WB: begin
        RegWrite = 1'b1;  RegDst = 1'b1;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;  ALUSrcB = SRCB_IMM;  ALUout_load = 1'b1;
      end
      S_MEM_READ: IorD = 1'b1;
      S_MEM_WAIT: begin
        IorD = 1'b1;  mdr_load = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;  MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD = 1'b1;  mem_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;  ALUSrcB = SRCB_B;  PCSource = PC_ALUOUT;
        pc_load = (Operation == OP_BNE) ? !ALU_zero : ALU_zero;
      end
      S_JUMP: begin
        PCSource = PC_JUMP;  pc_load = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_HALT:    halted = 1'b1;
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
